// File: rtl/am_envelope_detector.sv
// ============================================================================
// Module      : am_envelope_detector
// Description : Rectifies an AM sample stream, tracks per-window carrier peaks
//               and averages 2**LOG2_AVG windows into a scaled distance word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module am_envelope_detector #(
  parameter int WIDTH          = 13,
  parameter int SINE_WIDTH     = 7,
  parameter int LOG2_MAX_DIST  = 11,
  parameter int WINDOW_LEN     = 5,
  parameter int LOG2_AVG       = 3,
  parameter int SETTLE_SAMPLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [SINE_WIDTH-1:0] sample_in,
  output logic [WIDTH-1:0]      distance_out,
  output logic                  out_valid,
  output logic                  clip
);

  localparam int c_RECT_W = SINE_WIDTH - 1;
  localparam int c_ACC_W  = c_RECT_W + LOG2_AVG;
  localparam int c_SCALE  = LOG2_MAX_DIST - c_RECT_W;
  localparam int c_SCNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int c_STL_W  = $clog2(SETTLE_SAMPLES + 2);

  localparam logic [0:0] c_ST_SETTLE = 1'b0;
  localparam logic [0:0] c_ST_TRACK  = 1'b1;

  logic [0:0]            r_state;
  logic [c_STL_W-1:0]    r_settle_cnt;
  logic [c_RECT_W-1:0]   r_rect;
  logic [c_RECT_W-1:0]   r_peak;
  logic [c_ACC_W-1:0]    r_acc;
  logic [c_SCNT_W-1:0]   r_sample_cnt;
  logic [LOG2_AVG-1:0]   r_win_cnt;
  logic [WIDTH-1:0]      r_distance;
  logic                  r_out_valid;
  logic                  r_clip;

  logic [SINE_WIDTH-1:0] w_neg;
  logic                  w_is_min;
  logic [c_RECT_W-1:0]   w_rect_next;
  logic [c_RECT_W-1:0]   w_peak_max;
  logic [c_ACC_W-1:0]    w_acc_sum;
  logic [c_RECT_W-1:0]   w_avg;
  logic [WIDTH-1:0]      w_dist;
  logic                  w_win_last;
  logic                  w_batch_last;

  // The most negative code has no positive twin, so it saturates to full scale.
  assign w_neg       = -sample_in;
  assign w_is_min    = (sample_in == {1'b1, {(SINE_WIDTH-1){1'b0}}});
  assign w_rect_next = w_is_min               ? {c_RECT_W{1'b1}} :
                       sample_in[SINE_WIDTH-1] ? c_RECT_W'(w_neg)  :
                                                 c_RECT_W'(sample_in);

  assign w_peak_max   = (r_rect > r_peak) ? r_rect : r_peak;
  assign w_acc_sum    = r_acc + c_ACC_W'(w_peak_max);
  assign w_avg        = c_RECT_W'(w_acc_sum >> LOG2_AVG);
  assign w_dist       = WIDTH'(w_avg) << c_SCALE;
  assign w_win_last   = (r_sample_cnt == c_SCNT_W'(WINDOW_LEN - 1));
  assign w_batch_last = (r_win_cnt == {LOG2_AVG{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_ST_SETTLE;
      r_settle_cnt <= '0;
      r_rect       <= '0;
      r_peak       <= '0;
      r_acc        <= '0;
      r_sample_cnt <= '0;
      r_win_cnt    <= '0;
      r_distance   <= '0;
      r_out_valid  <= 1'b0;
      r_clip       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (enable) begin
        r_rect <= w_rect_next;
        if (w_is_min) begin
          r_clip <= 1'b1;
        end
        case (r_state)
          // One extra edge flushes the reset value out of the rectifier stage.
          c_ST_SETTLE: begin
            if (r_settle_cnt == c_STL_W'(SETTLE_SAMPLES)) begin
              r_state <= c_ST_TRACK;
            end else begin
              r_settle_cnt <= r_settle_cnt + c_STL_W'(1);
            end
          end
          default: begin
            if (w_win_last) begin
              r_peak       <= '0;
              r_sample_cnt <= '0;
              r_win_cnt    <= r_win_cnt + LOG2_AVG'(1);
              if (w_batch_last) begin
                r_acc       <= '0;
                r_distance  <= w_dist;
                r_out_valid <= 1'b1;
              end else begin
                r_acc <= w_acc_sum;
              end
            end else begin
              r_peak       <= w_peak_max;
              r_sample_cnt <= r_sample_cnt + c_SCNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign distance_out = r_distance;
  assign out_valid    = r_out_valid;
  assign clip         = r_clip;

endmodule

`default_nettype wire

// File: tb/tb_am_envelope_detector.sv
// ============================================================================
// Module      : tb_am_envelope_detector
// Description : Directed self-checking bench for am_envelope_detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_am_envelope_detector;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic signed [6:0] sample_in;
  logic [12:0]       distance_out;
  logic              out_valid;
  logic              clip;

  int n_cmp;
  int n_err;
  int feed_idx;
  int gap_pulses;
  int pulse_idx[$];
  int pulse_dist[$];

  logic signed [6:0] pat[5];

  am_envelope_detector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .distance_out (distance_out),
    .out_valid    (out_valid),
    .clip         (clip)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic signed [6:0] s);
    sample_in = s;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    feed_idx++;
    if (out_valid) begin
      pulse_idx.push_back(feed_idx);
      pulse_dist.push_back(int'(distance_out));
    end
  endtask

  task automatic idle();
    enable = 1'b0;
    @(posedge clk);
    #1;
    if (out_valid) gap_pulses++;
  endtask

  task automatic clear_log();
    feed_idx   = 0;
    gap_pulses = 0;
    pulse_idx.delete();
    pulse_dist.delete();
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    sample_in = '0;
    reset_n   = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pat[0] = 7'sd0;  pat[1] = 7'sd20; pat[2] = 7'sd32;
    pat[3] = -7'sd20; pat[4] = -7'sd32;

    // Reset state
    do_reset();
    check("reset_distance", int'(distance_out), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_clip", int'(clip), 0);

    // A: constant 63, first pulse on the edge after the 42nd capture
    for (int i = 0; i < 43; i++) feed(7'sd63);
    check("A_pulse_count", pulse_idx.size(), 1);
    if (pulse_idx.size() > 0) begin
      check("A_pulse_edge", pulse_idx[0], 43);
      check("A_distance", pulse_dist[0], 2016);
    end
    check("A_clip", int'(clip), 0);
    idle();
    check("A_valid_one_cycle", int'(out_valid), 0);
    check("A_distance_hold", int'(distance_out), 2016);

    // B: 32-peak pattern, three batches, period 40
    do_reset();
    feed(7'sd0); feed(7'sd0);
    for (int i = 0; i < 121; i++) feed(pat[i % 5]);
    check("B_pulse_count", pulse_idx.size(), 3);
    for (int i = 0; i < pulse_idx.size(); i++) begin
      check("B_pulse_edge", pulse_idx[i], 43 + 40 * i);
      check("B_distance", pulse_dist[i], 1024);
    end

    // C: most negative sample saturates and latches clip
    do_reset();
    feed(-7'sd64);
    check("C_clip_set", int'(clip), 1);
    for (int i = 0; i < 42; i++) feed(-7'sd64);
    check("C_pulse_count", pulse_idx.size(), 1);
    if (pulse_dist.size() > 0) check("C_distance", pulse_dist[0], 2016);
    for (int i = 0; i < 5; i++) feed(7'sd0);
    check("C_clip_sticky", int'(clip), 1);

    // F: asynchronous reset mid-batch
    for (int i = 0; i < 20; i++) feed(7'sd63);
    #3;
    reset_n = 1'b0;
    #1;
    check("F_async_distance", int'(distance_out), 0);
    check("F_async_valid", int'(out_valid), 0);
    check("F_async_clip", int'(clip), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    for (int i = 0; i < 42; i++) feed(7'sd63);
    check("F_no_early_pulse", pulse_idx.size(), 0);
    feed(7'sd63);
    check("F_pulse_count", pulse_idx.size(), 1);
    if (pulse_idx.size() > 0) check("F_pulse_edge", pulse_idx[0], 43);

    // D: alternating window peaks 40 and 8 -> average 24
    do_reset();
    feed(7'sd0); feed(7'sd0);
    for (int w = 0; w < 8; w++) begin
      if (w % 2 == 0) begin
        feed(7'sd40); feed(7'sd0); feed(7'sd0); feed(7'sd0); feed(7'sd0);
      end else begin
        feed(7'sd8); feed(-7'sd3); feed(7'sd2); feed(7'sd0); feed(7'sd1);
      end
    end
    feed(7'sd0);
    check("D_pulse_count", pulse_idx.size(), 1);
    if (pulse_dist.size() > 0) check("D_distance", pulse_dist[0], 768);

    // E: 10-cycle enable gap mid-window must not change the result
    do_reset();
    feed(7'sd0); feed(7'sd0);
    for (int i = 0; i < 41; i++) begin
      feed(pat[i % 5]);
      if (i == 12) for (int g = 0; g < 10; g++) idle();
    end
    check("E_gap_pulses", gap_pulses, 0);
    check("E_pulse_count", pulse_idx.size(), 1);
    if (pulse_idx.size() > 0) begin
      check("E_pulse_edge", pulse_idx[0], 43);
      check("E_distance", pulse_dist[0], 1024);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/am_envelope_detector.md
AM_ENVELOPE_DETECTOR -- requirements
Module: am_envelope_detector

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 13, bit width of distance_out.
- SINE_WIDTH, 7, bit width of the AM sample.
- LOG2_MAX_DIST, 11, full-scale distance is 2**LOG2_MAX_DIST.
- WINDOW_LEN, 5, samples per carrier period (10 MHz carrier at 50 MHz clk).
- LOG2_AVG, 3, log2 of the number of windows averaged (8).
- SETTLE_SAMPLES, 2, samples discarded after reset.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock; all state changes on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, sample strobe; the pipeline advances only on edges where it is high.
- sample_in, input, SINE_WIDTH, AM sample, two's complement.
- distance_out, output, WIDTH, recovered distance, registered.
- out_valid, output, 1, one-cycle pulse marking a new distance_out.
- clip, output, 1, sticky flag: a sample equal to -2**(SINE_WIDTH-1) was seen.

Function
REQ-003 Stage 1 SHALL register rect = |sample_in| on each enabled edge, saturating -64 to 63, giving a (SINE_WIDTH-1)-bit unsigned value.
REQ-004 The FSM SHALL have two states, SETTLE and TRACK; it SHALL enter SETTLE on reset.
REQ-005 In SETTLE, the first SETTLE_SAMPLES enabled samples SHALL be discarded. After that count the FSM SHALL go to TRACK, and it SHALL never return to SETTLE except through reset.
REQ-006 In TRACK, sample_cnt SHALL count 0..WINDOW_LEN-1 and wrap. win_cnt SHALL increment on each sample_cnt wrap, counting 0..2**LOG2_AVG-1 and wrapping.
REQ-007 Peak stage: peak <= max(peak, rect) on each enabled edge. On the edge that processes the last sample of a window, peak SHALL clear to 0 and acc <= acc + max(peak, rect).
REQ-008 acc SHALL be SINE_WIDTH-1+LOG2_AVG bits wide and SHALL never overflow.
REQ-009 On the edge that closes the last window (win_cnt = 2**LOG2_AVG-1), the block SHALL:
- set distance_out <= ((acc + max(peak, rect)) >> LOG2_AVG) << (LOG2_MAX_DIST-(SINE_WIDTH-1)), zero-extended to WIDTH;
- clear acc to 0;
- assert out_valid for exactly one cycle.
REQ-010 Latency SHALL be two enabled edges: the final sample of a batch is captured into rect at edge k, and distance_out/out_valid update at edge k+1.
REQ-011 out_valid SHALL deassert on the next clk edge regardless of enable. distance_out SHALL hold its value between updates.
REQ-012 When enable is low, all counters, peak, acc and the FSM state SHALL hold. A window spanning an enable gap SHALL give the same result as the same samples without the gap.
REQ-013 clip SHALL set on capture of a saturated sample. It SHALL clear only on reset.
REQ-014 The first out_valid after reset SHALL follow exactly SETTLE_SAMPLES + WINDOW_LEN*2**LOG2_AVG enabled samples (2+40 with defaults).

Reset
REQ-015 On reset_n low, asynchronously and regardless of clk, the block SHALL:
- clear distance_out, out_valid, clip, rect, peak, acc, sample_cnt and win_cnt to 0;
- put the FSM in SETTLE.
REQ-016 Reset asserted mid-batch SHALL discard the partial batch. After release, the SETTLE count SHALL restart.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Constant sample_in = 63, enable high -> out_valid on the cycle after the 42nd sample is captured; distance_out = 2016; clip = 0.
- Repeating [0,20,32,-20,-32] after settle -> distance_out = 1024 on every 8-window batch; out_valid period = 40 cycles.
- sample_in = -64 constant -> distance_out = 2016; clip = 1, and it stays 1 after input returns to 0.
- Batch alternating windows with peaks 40 and 8 -> (4*40 + 4*8)>>3 = 24 -> distance_out = 768.
- enable low for 10 cycles mid-window of the 32-peak pattern -> same distance_out = 1024; no out_valid during the gap.
- reset_n pulsed low mid-batch -> all outputs 0 immediately; next out_valid only after 42 further enabled samples.
